// File: rtl/seq_div25x9_if.sv
// Request/result bundle for the sequential 25/9 restoring divider.
// The master drives the operands and start; the divider drives results and status.
interface seq_div25x9_if #(
  parameter int QW = 16,
  parameter int DW = 9
);
  logic              start;
  logic [QW+DW-1:0]  in_Dvd;
  logic [DW-1:0]     in_Dvs;
  logic [QW-1:0]     Quot;
  logic [DW-1:0]     Rem;
  logic              busy;
  logic              done;
  logic              dz;
  logic              ovf;

  modport master (
    output start, in_Dvd, in_Dvs,
    input  Quot, Rem, busy, done, dz, ovf
  );

  modport slave (
    input  start, in_Dvd, in_Dvs,
    output Quot, Rem, busy, done, dz, ovf
  );
endinterface

// File: rtl/seq_div25x9.sv
// Sequential restoring divider, one quotient bit per clock: (QW+DW)-bit dividend by
// DW-bit divisor, with divide-by-zero and quotient-overflow detection at accept time.
module seq_div25x9 #(
  parameter int QW = 16,
  parameter int DW = 9
) (
  input  logic              CLK,
  input  logic              RESET,
  seq_div25x9_if.slave      bus
);
  localparam int CW = $clog2(QW);
  localparam logic [CW-1:0] LAST = CW'(QW - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_reg;
  logic [DW-1:0]   pr_reg;
  logic [QW-1:0]   sh_reg;
  logic [DW-1:0]   dvs_reg;
  logic [CW-1:0]   cnt_reg;
  logic [QW-1:0]   quot_reg;
  logic [DW-1:0]   rem_reg;
  logic            busy_reg;
  logic            done_reg;
  logic            dz_reg;
  logic            ovf_reg;

  logic [DW:0]     trial;
  logic            fits;
  logic [DW-1:0]   pr_next;
  logic [QW-1:0]   sh_next;

  // The partial remainder stays below the divisor, so it never needs more than DW
  // bits; only the trial value carries the extra shifted-in bit.
  always_comb begin
    trial   = {pr_reg, sh_reg[QW-1]};
    fits    = (trial >= {1'b0, dvs_reg});
    pr_next = fits ? DW'(trial - {1'b0, dvs_reg}) : trial[DW-1:0];
    // Dividend bits leave at the top while quotient bits enter at the bottom.
    sh_next = {sh_reg[QW-2:0], fits};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= IDLE;
      pr_reg    <= '0;
      sh_reg    <= '0;
      dvs_reg   <= '0;
      cnt_reg   <= '0;
      quot_reg  <= '0;
      rem_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      dz_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            if (bus.in_Dvs == '0) begin
              dz_reg    <= 1'b1;
              ovf_reg   <= 1'b0;
              quot_reg  <= '1;
              rem_reg   <= '1;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else if (bus.in_Dvd[QW+DW-1:QW] >= bus.in_Dvs) begin
              // Top bits already reach the divisor: quotient needs more than QW bits.
              dz_reg    <= 1'b0;
              ovf_reg   <= 1'b1;
              quot_reg  <= '1;
              rem_reg   <= '1;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              dz_reg    <= 1'b0;
              ovf_reg   <= 1'b0;
              pr_reg    <= bus.in_Dvd[QW+DW-1:QW];
              sh_reg    <= bus.in_Dvd[QW-1:0];
              dvs_reg   <= bus.in_Dvs;
              cnt_reg   <= '0;
              busy_reg  <= 1'b1;
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          pr_reg  <= pr_next;
          sh_reg  <= sh_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            quot_reg  <= sh_next;
            rem_reg   <= pr_next;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.Quot = quot_reg;
  assign bus.Rem  = rem_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.dz   = dz_reg;
  assign bus.ovf  = ovf_reg;
endmodule
